// File: rtl/calckit_pkg.sv
// calckit_pkg: definitions shared by the CalcKit keypad front end and the
// number parser.
//   - keypad FSM state encoding (KP_*)
//   - key code constants KEY_0..KEY_F
//   - kp_keymap(): row/column position -> key code
package calckit_pkg;

    localparam logic [1:0] KP_SCAN     = 2'd0;
    localparam logic [1:0] KP_DEBOUNCE = 2'd1;
    localparam logic [1:0] KP_HOLD     = 2'd2;
    localparam logic [1:0] KP_RELEASE  = 2'd3;

    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    // Row 3 carries '*' (E) and '#' (F) either side of the 0 key.
    function automatic logic [3:0] kp_keymap(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = KEY_1;
            4'b00_01: code = KEY_2;
            4'b00_10: code = KEY_3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = KEY_4;
            4'b01_01: code = KEY_5;
            4'b01_10: code = KEY_6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = KEY_7;
            4'b10_01: code = KEY_8;
            4'b10_10: code = KEY_9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_E;
            4'b11_01: code = KEY_0;
            4'b11_10: code = KEY_F;
            default:  code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs.
// Ports:
//   clk  in          sampling clock
//   rst  in          synchronous active-high reset (both flops -> RESET_VALUE)
//   d    in  [W-1:0] asynchronous input
//   q    out [W-1:0] synchronized output, two cycles behind d
module sync_2ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce and a valid/ready
// key output.
// Ports:
//   clk        in      system clock
//   rst        in      synchronous active-high reset
//   key_row    in  [4] row lines, active low, asynchronous
//   key_col    out [4] column drive, active low, one-cold
//   key_code   out [4] code of the accepted key, stable while key_valid
//   key_valid  out     key available
//   key_ready  in      consumer takes the key
//   key_held   out     debounced key currently held
//   overrun    out     one-cycle pulse when an unconsumed key is overwritten
// Build option: define KEYPAD_AUTOREPEAT_EN to re-emit a held key after
// REPEAT_DELAY samples and then every REPEAT_RATE samples.
//
// state       | meaning
// KP_SCAN     | rotate columns, look for exactly one low row
// KP_DEBOUNCE | column frozen, count matching samples of the captured row
// KP_HOLD     | key accepted and held, waiting for all rows high
// KP_RELEASE  | column frozen, counting all-high samples before rescanning
module keypad_scanner
    import calckit_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int DEBOUNCE_CNT = 20,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("keypad_scanner: parameter out of range");
    end

    logic [3:0]       row_s;
    logic [DIV_W-1:0] div;
    logic             sample;
    logic [1:0]       col_idx, col_nxt;
    logic [1:0]       state, state_nxt;
    logic [3:0]       cap_pat, cap_pat_nxt;
    logic [1:0]       cap_row, cap_row_nxt;
    logic [CNT_W-1:0] match_cnt, match_nxt;
    logic [CNT_W-1:0] rel_cnt, rel_nxt;
    logic [3:0]       row_low;
    logic             row_single;
    logic [1:0]       row_idx;
    logic             emit;
    logic [3:0]       emit_code;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_LOAD_DLY  = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_LOAD_RATE = REP_W'(REPEAT_RATE);
    localparam logic [REP_W-1:0] REP_ONE       = REP_W'(1);
    logic [REP_W-1:0] rep_cnt, rep_nxt;
`endif

    sync_2ff #(.WIDTH(4), .RESET_VALUE(4'hF)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_row),
        .q   (row_s)
    );

    assign sample     = (div == DIV_LAST);
    assign key_col    = ~(4'b0001 << col_idx);
    assign key_held   = (state == KP_HOLD) || (state == KP_RELEASE);
    assign row_low    = ~row_s;
    // Exactly one row low; two or more is ghosting and is not a press.
    assign row_single = (row_low != 4'h0) && ((row_low & (row_low - 4'h1)) == 4'h0);

    always_comb begin
        row_idx = 2'd0;
        case (row_s)
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    // In SCAN the row is only being captured this cycle, so use it directly.
    assign emit_code = kp_keymap((state == KP_SCAN) ? row_idx : cap_row, col_idx);

    always_comb begin
        state_nxt   = state;
        col_nxt     = col_idx;
        cap_pat_nxt = cap_pat;
        cap_row_nxt = cap_row;
        match_nxt   = match_cnt;
        rel_nxt     = rel_cnt;
        emit        = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_nxt     = (state == KP_HOLD) ? rep_cnt : REP_LOAD_DLY;
`endif
        if (sample) begin
            case (state)
                KP_SCAN: begin
                    if (row_single) begin
                        cap_pat_nxt = row_s;
                        cap_row_nxt = row_idx;
                        match_nxt   = CNT_W'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            emit      = 1'b1;
                            state_nxt = KP_HOLD;
                        end else begin
                            state_nxt = KP_DEBOUNCE;
                        end
                    end else begin
                        col_nxt = col_idx + 2'd1;
                    end
                end
                KP_DEBOUNCE: begin
                    if (row_s == cap_pat) begin
                        if (match_cnt == CNT_LAST) begin
                            emit      = 1'b1;
                            match_nxt = '0;
                            state_nxt = KP_HOLD;
                        end else begin
                            match_nxt = match_cnt + 1'b1;
                        end
                    end else begin
                        match_nxt = '0;
                        state_nxt = KP_SCAN;
                        col_nxt   = col_idx + 2'd1;
                    end
                end
                KP_HOLD: begin
                    if (row_s == 4'hF) begin
                        if (DEBOUNCE_CNT == 1) begin
                            rel_nxt   = '0;
                            state_nxt = KP_SCAN;
                            col_nxt   = col_idx + 2'd1;
                        end else begin
                            rel_nxt   = CNT_W'(1);
                            state_nxt = KP_RELEASE;
                        end
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (rep_cnt == REP_ONE) begin
                        emit    = 1'b1;
                        rep_nxt = REP_LOAD_RATE;
                    end else begin
                        rep_nxt = rep_cnt - 1'b1;
                    end
`endif
                end
                KP_RELEASE: begin
                    if (row_s == 4'hF) begin
                        if (rel_cnt == CNT_LAST) begin
                            rel_nxt   = '0;
                            state_nxt = KP_SCAN;
                            col_nxt   = col_idx + 2'd1;
                        end else begin
                            rel_nxt = rel_cnt + 1'b1;
                        end
                    end else begin
                        rel_nxt   = '0;
                        state_nxt = KP_HOLD;
                    end
                end
                default: state_nxt = KP_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div       <= '0;
            col_idx   <= 2'd0;
            state     <= KP_SCAN;
            cap_pat   <= 4'hF;
            cap_row   <= 2'd0;
            match_cnt <= '0;
            rel_cnt   <= '0;
            key_code  <= KEY_0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            div       <= sample ? '0 : div + 1'b1;
            col_idx   <= col_nxt;
            state     <= state_nxt;
            cap_pat   <= cap_pat_nxt;
            cap_row   <= cap_row_nxt;
            match_cnt <= match_nxt;
            rel_cnt   <= rel_nxt;
            overrun   <= 1'b0;
            // A new key beats a same-cycle accept: valid stays up, no overrun.
            if (emit) begin
                key_code  <= emit_code;
                key_valid <= 1'b1;
                overrun   <= key_valid && !key_ready;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    // Down-counter of HOLD samples until the next repeat; reloaded whenever
    // the FSM is outside HOLD so each hold starts a fresh delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_nxt;
        end
    end
`endif

endmodule
